// File: rtl/serial_rx_controller.sv
// serial_rx_controller: handshakes bits out of the serial Receiver, assembles
// LSB-first words, and buffers them in a show-ahead FIFO for the host.
// Optional feature: define SERIAL_RX_PARITY_EN to add an even-parity bit per
// word and drive parity_err; otherwise parity_err is tied low.
module serial_rx_controller #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_available,
  input  logic                          rx_bit,
  output logic                          rx_fetched,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          clr_err,
  output logic                          overrun,
  output logic                          timeout_err,
  output logic                          parity_err
);

`ifdef SERIAL_RX_PARITY_EN
  localparam int WORD_BITS = DATA_BITS + 1;
`else
  localparam int WORD_BITS = DATA_BITS;
`endif
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(WORD_BITS + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {COLLECT, RELEASE, PUSH} state_t;

  state_t                 state_q, state_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0]   sh_q, sh_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   fetched_q, fetched_d;
  logic                   push_vld_q, push_vld_d;
  logic [DATA_BITS-1:0]   push_word_q, push_word_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overrun_q, overrun_d, timeout_q, timeout_d;
  logic                   sample_en, push_en, tmo_hit, wr_ok, rd_ok;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // FSM next state: four-phase handshake per bit, one PUSH cycle per word
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (rx_available) state_d = RELEASE;
      RELEASE: if (!rx_available)
                 state_d = (bit_cnt_q == BCW'(WORD_BITS)) ? PUSH : COLLECT;
      PUSH:    state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM outputs: fetched follows rx_available while a bit is being taken
  always_comb begin
    sample_en = 1'b0;
    push_en   = 1'b0;
    fetched_d = 1'b0;
    case (state_q)
      COLLECT: begin
        sample_en = rx_available;
        fetched_d = rx_available;
      end
      RELEASE: fetched_d = rx_available;
      PUSH:    push_en = 1'b1;
      default: ;
    endcase
  end

  // Word assembly and inter-bit timeout
  always_comb begin
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_d       = tmo_q;
    tmo_hit     = 1'b0;
    if (sample_en) begin
      for (int i = 0; i < WORD_BITS; i++)
        if (bit_cnt_q == BCW'(i)) sh_d[i] = rx_bit;
      bit_cnt_d = bit_cnt_q + 1'b1;
      tmo_d     = '0;
    end else if (state_q == COLLECT && bit_cnt_q != '0 && !rx_available) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        tmo_hit   = 1'b1;
        tmo_d     = '0;
        bit_cnt_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    if (push_en) bit_cnt_d = '0;
    push_vld_d  = push_en;
    push_word_d = sh_q[DATA_BITS-1:0];
  end

  // FIFO pointers, occupancy and sticky error flags
  always_comb begin
    wr_ok    = push_vld_q & ~fifo_full;
    rd_ok    = rd_en & ~fifo_empty;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (!wr_ok && rd_ok) count_d = count_q - 1'b1;
    overrun_d = (overrun_q & ~clr_err) | (push_vld_q & fifo_full);
    timeout_d = (timeout_q & ~clr_err) | tmo_hit;
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      tmo_q      <= '0;
      fetched_q  <= 1'b0;
      push_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      tmo_q      <= tmo_d;
      fetched_q  <= fetched_d;
      push_vld_q <= push_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  // Data registers and FIFO storage; validity is tracked by control state
  always_ff @(posedge clk) begin
    sh_q        <= sh_d;
    push_word_q <= push_word_d;
    if (wr_ok) mem_q[wr_ptr_q] <= push_word_q;
  end

`ifdef SERIAL_RX_PARITY_EN
  logic parity_q, parity_d;

  // Even parity over data+parity, checked as the word leaves the shifter
  always_comb parity_d = (parity_q & ~clr_err) | (push_en & (^sh_q));

  // Sticky parity flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end
  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_fetched  = fetched_q;
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  assign fifo_count  = count_q;
  assign rd_data     = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule
